// File: rtl/mem_ctrl_line.sv
// mem_ctrl_line: byte-serial arbiter between ICache line refill and LSB
// byte/half/word loads and stores on an 8-bit RAM/IO bus.
module mem_ctrl_line #(
    parameter int          LINE_BYTES = 16,
    parameter logic [31:0] IO_MASK    = 32'h0003_0000,
    parameter logic [31:0] IO_MATCH   = 32'h0003_0000,
    parameter int          IO_GAP     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    jp_wrong,
    input  logic                    ic_req,
    input  logic [31:0]             ic_addr,
    output logic                    ic_ready,
    output logic [8*LINE_BYTES-1:0] ic_line,
    input  logic                    lsb_req,
    input  logic                    lsb_we,
    input  logic [1:0]              lsb_size,
    input  logic                    lsb_signed,
    input  logic [31:0]             lsb_addr,
    input  logic [31:0]             lsb_wdata,
    output logic                    lsb_done,
    output logic [31:0]             lsb_rdata,
    input  logic                    io_buffer_full,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [31:0]             mem_a,
    output logic                    mem_wr
);
    localparam int LB = $clog2(LINE_BYTES);
    localparam int CW = LB + 1;

    typedef enum logic [2:0] {IDLE, IC_RD, LS_RD, LS_WR, IO_WAIT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rbuf_q, rbuf_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [8*LINE_BYTES-1:0] line_q, line_d;
    logic [1:0]              size_q, size_d;
    logic                    sgn_q, sgn_d, we_q, we_d;
    logic                    io_q, io_d, isic_q, isic_d;
    logic                    issued_q, issued_d, pend_q, pend_d;
    logic [2:0]              gap_q, gap_d;

    logic [CW-1:0] nbytes, cidx;
    logic          can_issue, kill, lsb_io, mem_wr_c, rd_state;
    logic [31:0]   mem_a_c;
    logic [7:0]    mem_dout_c;

    always_comb begin
        unique case (size_q)
            2'd0:    nbytes = CW'(1);
            2'd1:    nbytes = CW'(2);
            default: nbytes = CW'(4);
        endcase
        if (isic_q) nbytes = CW'(LINE_BYTES);
    end

    assign lsb_io    = (lsb_addr & IO_MASK) == IO_MATCH;
    assign can_issue = !io_q || (!io_buffer_full && gap_q == 3'd0);
    // An IO load whose first byte went out cannot be undone.
    assign kill      = rdy && jp_wrong && !we_q && !(io_q && issued_q);
    assign rd_state  = (state_q == IC_RD) || (state_q == LS_RD);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        rdata_d    = rdata_q;
        line_d     = line_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        we_d       = we_q;
        io_d       = io_q;
        isic_d     = isic_q;
        issued_d   = issued_q;
        pend_d     = pend_q;
        gap_d      = (gap_q != 3'd0) ? gap_q - 3'd1 : 3'd0;
        cidx       = cnt_q - CW'(1);
        mem_a_c    = '0;
        mem_dout_c = '0;
        mem_wr_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!jp_wrong && lsb_req) begin
                    addr_d   = lsb_addr;
                    size_d   = lsb_size;
                    sgn_d    = lsb_signed;
                    we_d     = lsb_we;
                    wdata_d  = lsb_wdata;
                    io_d     = lsb_io;
                    isic_d   = 1'b0;
                    cnt_d    = '0;
                    issued_d = 1'b0;
                    pend_d   = 1'b0;
                    rbuf_d   = '0;
                    if (lsb_io && (io_buffer_full || gap_q != 3'd0))
                        state_d = IO_WAIT;
                    else
                        state_d = lsb_we ? LS_WR : LS_RD;
                end else if (!jp_wrong && ic_req) begin
                    addr_d   = {ic_addr[31:LB], LB'(0)};
                    we_d     = 1'b0;
                    io_d     = 1'b0;
                    isic_d   = 1'b1;
                    cnt_d    = '0;
                    issued_d = 1'b0;
                    pend_d   = 1'b0;
                    state_d  = IC_RD;
                end
            end
            IO_WAIT: begin
                if (kill)
                    state_d = IDLE;
                else if (!io_buffer_full && gap_q == 3'd0)
                    state_d = we_q ? LS_WR : LS_RD;
            end
            IC_RD, LS_RD: begin
                if (kill) begin
                    state_d = IDLE;
                    pend_d  = 1'b0;
                end else begin
                    if (pend_q) begin
                        pend_d = 1'b0;
                        if (isic_q) line_d[8*int'(cidx) +: 8] = mem_din;
                        else        rbuf_d[8*int'(cidx[1:0]) +: 8] = mem_din;
                    end
                    if (cnt_q == nbytes) begin
                        state_d = DONE;
                        if (!isic_q) begin
                            unique case (size_q)
                                2'd0:    rdata_d = {{24{sgn_q & rbuf_d[7]}}, rbuf_d[7:0]};
                                2'd1:    rdata_d = {{16{sgn_q & rbuf_d[15]}}, rbuf_d[15:0]};
                                default: rdata_d = rbuf_d;
                            endcase
                        end
                    end else if (can_issue) begin
                        mem_a_c  = addr_q + 32'(cnt_q);
                        cnt_d    = cnt_q + CW'(1);
                        pend_d   = 1'b1;
                        issued_d = 1'b1;
                        if (io_q) gap_d = 3'(IO_GAP);
                    end
                end
            end
            LS_WR: begin
                if (can_issue) begin
                    mem_wr_c   = 1'b1;
                    mem_a_c    = addr_q + 32'(cnt_q);
                    mem_dout_c = wdata_q[8*int'(cnt_q[1:0]) +: 8];
                    issued_d   = 1'b1;
                    if (io_q) gap_d = 3'(IO_GAP);
                    if (cnt_q == nbytes - CW'(1)) state_d = DONE;
                    else                          cnt_d   = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rbuf_q   <= '0;
            rdata_q  <= '0;
            line_q   <= '0;
            size_q   <= '0;
            sgn_q    <= 1'b0;
            we_q     <= 1'b0;
            io_q     <= 1'b0;
            isic_q   <= 1'b0;
            issued_q <= 1'b0;
            pend_q   <= 1'b0;
            gap_q    <= '0;
        end else if (rdy) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rbuf_q   <= rbuf_d;
            rdata_q  <= rdata_d;
            line_q   <= line_d;
            size_q   <= size_d;
            sgn_q    <= sgn_d;
            we_q     <= we_d;
            io_q     <= io_d;
            isic_q   <= isic_d;
            issued_q <= issued_d;
            pend_q   <= pend_d;
            gap_q    <= gap_d;
        end
    end

    assign ic_ready  = (state_q == DONE) && isic_q && !kill;
    assign lsb_done  = (state_q == DONE) && !isic_q && !kill;
    assign ic_line   = line_q;
    assign lsb_rdata = rdata_q;
    assign mem_wr    = mem_wr_c && rdy;
    assign mem_dout  = mem_dout_c;
    // While frozen, keep the pending byte's address on the bus so mem_din
    // still carries that byte when the clock enable returns.
    assign mem_a     = (!rdy && pend_q && rd_state) ? addr_q + 32'(cidx) : mem_a_c;
endmodule

// File: tb/tb_mem_ctrl_line.sv
// tb_mem_ctrl_line: directed bench for mem_ctrl_line with a 4 KiB RAM
// model (address bits 11:0) and a bus write log.
module tb_mem_ctrl_line;
    localparam int GAP = 1;

    logic         clk = 1'b0;
    logic         rst, rdy, jp_wrong, ic_req;
    logic [31:0]  ic_addr;
    logic         ic_ready;
    logic [127:0] ic_line;
    logic         lsb_req, lsb_we, lsb_signed;
    logic [1:0]   lsb_size;
    logic [31:0]  lsb_addr, lsb_wdata;
    logic         lsb_done;
    logic [31:0]  lsb_rdata;
    logic         io_buffer_full;
    logic [7:0]   mem_din;
    logic [7:0]   mem_dout;
    logic [31:0]  mem_a;
    logic         mem_wr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0]  ram [0:4095];
    logic        pl_we;
    logic [11:0] pl_a;
    logic [7:0]  pl_d;
    int          wcyc[$];
    logic [31:0] wadr[$];
    logic [7:0]  wdat[$];

    mem_ctrl_line dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jp_wrong(jp_wrong),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_line(ic_line),
        .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_size(lsb_size),
        .lsb_signed(lsb_signed), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
        .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        mem_din <= ram[mem_a[11:0]];
        if (mem_wr) begin
            ram[mem_a[11:0]] <= mem_dout;
            wcyc.push_back(cyc);
            wadr.push_back(mem_a);
            wdat.push_back(mem_dout);
        end else if (pl_we) begin
            ram[pl_a] <= pl_d;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        pl_we = 1'b1;
        pl_a  = a;
        pl_d  = d;
        step();
        pl_we = 1'b0;
    endtask

    task automatic wait_pulse(input bit ic, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            step();
            got = ic ? ic_ready : lsb_done;
        end
        chk({tag, "_pulse"}, 128'(got), 128'(1));
    endtask

    task automatic lsb_set(input bit we, input logic [1:0] sz, input bit sg,
                           input logic [31:0] a, input logic [31:0] wd);
        lsb_req    = 1'b1;
        lsb_we     = we;
        lsb_size   = sz;
        lsb_signed = sg;
        lsb_addr   = a;
        lsb_wdata  = wd;
    endtask

    task automatic do_load(input logic [1:0] sz, input bit sg, input logic [31:0] a,
                           input logic [31:0] exp, input string tag);
        lsb_set(1'b0, sz, sg, a, 32'h0);
        wait_pulse(1'b0, tag);
        chk(tag, 128'(lsb_rdata), 128'(exp));
        lsb_req = 1'b0;
        step();
    endtask

    task automatic chk_writes(input int w0, input logic [31:0] a, input logic [31:0] v,
                              input string tag);
        logic [31:0] vv;
        vv = v;
        chk({tag, "_count"}, 128'(wadr.size() - w0), 128'(4));
        if (wadr.size() >= w0 + 4) begin
            for (int k = 0; k < 4; k++) begin
                chk({tag, "_addr"}, 128'(wadr[w0+k]), 128'(a + 32'(k)));
                chk({tag, "_data"}, 128'(wdat[w0+k]), 128'(vv[8*k +: 8]));
            end
            chk({tag, "_contig"}, 128'(wcyc[w0+3] - wcyc[w0]), 128'(3));
        end
    endtask

    initial begin
        logic [127:0] exp_line;
        int           w0;
        int           hits;

        rst = 1'b1; rdy = 1'b1; jp_wrong = 1'b0;
        ic_req = 1'b0; ic_addr = '0;
        lsb_req = 1'b0; lsb_we = 1'b0; lsb_size = '0; lsb_signed = 1'b0;
        lsb_addr = '0; lsb_wdata = '0; io_buffer_full = 1'b0;
        pl_we = 1'b0; pl_a = '0; pl_d = '0;
        step();
        step();
        chk("rst_ic_ready", 128'(ic_ready), 128'(0));
        chk("rst_lsb_done", 128'(lsb_done), 128'(0));
        chk("rst_ic_line", ic_line, 128'(0));
        chk("rst_rdata", 128'(lsb_rdata), 128'(0));
        chk("rst_mem_a", 128'(mem_a), 128'(0));
        chk("rst_mem_wr", 128'(mem_wr), 128'(0));
        chk("rst_mem_dout", 128'(mem_dout), 128'(0));
        rst = 1'b0;
        step();

        for (int k = 0; k < 16; k++) begin
            poke(12'h230 + 12'(k), 8'hA0 + 8'(k));
            exp_line[8*k +: 8] = 8'hA0 + 8'(k);
        end
        poke(12'h100, 8'h80);
        poke(12'h101, 8'h80);
        poke(12'h102, 8'hFF);
        poke(12'h10C, 8'h78);
        poke(12'h10D, 8'h56);
        poke(12'h10E, 8'h34);
        poke(12'h10F, 8'h12);
        poke(12'hFFE, 8'h01);
        poke(12'hFFF, 8'h02);
        poke(12'h000, 8'h03);
        poke(12'h001, 8'h04);

        // IC refill: request seen in cycle 0
        ic_req = 1'b1;
        ic_addr = 32'h1234;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("ic_mem_a", 128'(mem_a), 128'(32'h1230 + 32'(i - 1)));
        end
        step();
        chk("ic_ready_c17", 128'(ic_ready), 128'(0));
        step();
        chk("ic_ready_c18", 128'(ic_ready), 128'(1));
        chk("ic_line", ic_line, exp_line);
        ic_req = 1'b0;
        step();
        chk("ic_ready_c19", 128'(ic_ready), 128'(0));
        chk("ic_idle_mem_a", 128'(mem_a), 128'(0));

        do_load(2'd0, 1'b1, 32'h100, 32'hFFFF_FF80, "lb");
        do_load(2'd0, 1'b0, 32'h100, 32'h0000_0080, "lbu");
        do_load(2'd1, 1'b0, 32'h101, 32'h0000_FF80, "lhu");
        do_load(2'd1, 1'b1, 32'h101, 32'hFFFF_FF80, "lh");
        do_load(2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0403_0201, "lw_wrap");
        do_load(2'd3, 1'b0, 32'h10C, 32'h1234_5678, "size3");

        // store wins over a simultaneous refill
        w0 = wadr.size();
        lsb_set(1'b1, 2'd2, 1'b0, 32'h200, 32'hDEAD_BEEF);
        ic_req = 1'b1;
        ic_addr = 32'h1234;
        wait_pulse(1'b0, "sw");
        chk("sw_ic_not_first", 128'(ic_ready), 128'(0));
        chk_writes(w0, 32'h200, 32'hDEAD_BEEF, "sw");
        lsb_req = 1'b0;
        wait_pulse(1'b1, "sw_then_ic");
        chk("sw_then_ic_line", ic_line, exp_line);
        ic_req = 1'b0;
        step();

        // IO store blocked by a full buffer, then a back-to-back IO store
        w0 = wadr.size();
        io_buffer_full = 1'b1;
        lsb_set(1'b1, 2'd0, 1'b0, 32'h0003_0000, 32'h5A);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("io_full_hold", 128'(mem_wr), 128'(0));
        end
        step();
        chk("io_full_hold", 128'(mem_wr), 128'(0));
        io_buffer_full = 1'b0;
        step();
        chk("io_wr", 128'(mem_wr), 128'(1));
        chk("io_wr_a", 128'(mem_a), 128'(32'h0003_0000));
        chk("io_wr_d", 128'(mem_dout), 128'(8'h5A));
        step();
        chk("io_done", 128'(lsb_done), 128'(1));
        lsb_set(1'b1, 2'd0, 1'b0, 32'h0003_0001, 32'hC3);
        wait_pulse(1'b0, "io_sb2");
        lsb_req = 1'b0;
        chk("io_wr_count", 128'(wadr.size() - w0), 128'(2));
        if (wadr.size() >= w0 + 2)
            chk("io_gap", 128'((wcyc[w0+1] - wcyc[w0] - 1) >= GAP), 128'(1));
        step();
        do_load(2'd1, 1'b0, 32'h0003_0000, 32'h0000_C35A, "io_lhu");

        // flush in the middle of a refill
        ic_req = 1'b1;
        ic_addr = 32'h1234;
        for (int i = 1; i <= 8; i++) step();
        chk("jp_ic_c7_addr", 128'(mem_a), 128'(32'h1237));
        jp_wrong = 1'b1;
        ic_req = 1'b0;
        step();
        jp_wrong = 1'b0;
        chk("jp_ic_idle", 128'(mem_a), 128'(0));
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            if (ic_ready) hits++;
            step();
        end
        chk("jp_ic_no_ready", 128'(hits), 128'(0));

        // flush in IDLE blocks acceptance for that cycle
        lsb_set(1'b0, 2'd0, 1'b0, 32'h100, 32'h0);
        jp_wrong = 1'b1;
        step();
        chk("jp_idle_hold", 128'(mem_a), 128'(0));
        jp_wrong = 1'b0;
        step();
        chk("jp_idle_then", 128'(mem_a), 128'(32'h100));
        wait_pulse(1'b0, "jp_idle_ld");
        chk("jp_idle_rdata", 128'(lsb_rdata), 128'(32'h80));
        lsb_req = 1'b0;
        step();

        // flush in the middle of a store is ignored
        w0 = wadr.size();
        lsb_set(1'b1, 2'd2, 1'b0, 32'h204, 32'h1122_3344);
        step();
        step();
        step();
        chk("jp_sw_b2_addr", 128'(mem_a), 128'(32'h206));
        jp_wrong = 1'b1;
        step();
        jp_wrong = 1'b0;
        chk("jp_sw_b3_wr", 128'(mem_wr), 128'(1));
        wait_pulse(1'b0, "jp_sw");
        chk_writes(w0, 32'h204, 32'h1122_3344, "jp_sw");
        lsb_req = 1'b0;
        step();

        // synchronous reset mid-store
        lsb_set(1'b1, 2'd2, 1'b0, 32'h208, 32'hCAFE_F00D);
        step();
        step();
        chk("rst_sw_busy", 128'(mem_wr), 128'(1));
        rst = 1'b1;
        lsb_req = 1'b0;
        step();
        chk("rst2_mem_wr", 128'(mem_wr), 128'(0));
        chk("rst2_mem_a", 128'(mem_a), 128'(0));
        chk("rst2_mem_dout", 128'(mem_dout), 128'(0));
        chk("rst2_lsb_done", 128'(lsb_done), 128'(0));
        chk("rst2_rdata", 128'(lsb_rdata), 128'(0));
        chk("rst2_ic_line", ic_line, 128'(0));
        rst = 1'b0;
        step();

        // freeze for 3 cycles mid-load
        lsb_set(1'b0, 2'd2, 1'b0, 32'h10C, 32'h0);
        step();
        step();
        rdy = 1'b0;
        step();
        chk("frz_done", 128'(lsb_done), 128'(0));
        step();
        chk("frz_done", 128'(lsb_done), 128'(0));
        step();
        rdy = 1'b1;
        wait_pulse(1'b0, "frz_lw");
        chk("frz_lw", 128'(lsb_rdata), 128'(32'h1234_5678));
        lsb_req = 1'b0;
        step();
        chk("frz_pulse_end", 128'(lsb_done), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
